// File: rtl/des_ahb_pkg.sv
// Shared definitions for the Triple DES AHB-Lite port: register map,
// register bit positions, AHB encodings and the block type.
package des_ahb_pkg;

   typedef logic [63:0] block_t;

   localparam logic [3:0] IDX_CTRL       = 4'd0;
   localparam logic [3:0] IDX_STATUS     = 4'd1;
   localparam logic [3:0] IDX_KEY0       = 4'd2;
   localparam logic [3:0] IDX_DATA_IN    = 4'd8;
   localparam logic [3:0] IDX_DATA_OUT   = 4'd9;
   localparam logic [3:0] IDX_RSVD_FIRST = 4'd10;

   localparam int CTRL_MODE  = 0;
   localparam int CTRL_FLUSH = 1;

   localparam int ST_IN_FULL   = 0;
   localparam int ST_IN_EMPTY  = 1;
   localparam int ST_OUT_FULL  = 2;
   localparam int ST_OUT_EMPTY = 3;
   localparam int ST_ERR       = 4;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ERR1,
      ERR2
   } err_state_t;

endpackage

// File: rtl/des_block_fifo.sv
// Synchronous FIFO of 64-bit blocks with flush; a push on a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module des_block_fifo
   import des_ahb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  block_t                   push_data,
   input  logic                     pop,
   output block_t                   pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   block_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign full     = (count == (PW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // Pointers and occupancy; flush has priority so a same-cycle push is dropped.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end

   // Storage array; contents are don't-care while the FIFO is empty.
   always_ff @(posedge clock) begin
      if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ahb_des_port.sv
// AHB-Lite slave port for the Triple DES engine: register file, block
// FIFOs toward the core, half-word assembly for 32-bit buses and the
// two-cycle ERROR response.
module ahb_des_port
   import des_ahb_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 4
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL,
   input  logic              HWRITE,
   input  logic              HMASTLOCK,
   input  logic              HREADY,
   input  logic [1:0]        HTRANS,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [3:0]        HPROT,
   input  logic [31:0]       HADDR,
   input  logic [DATA_W-1:0] HWDATA,
   output logic [DATA_W-1:0] HRDATA,
   output logic              HREADYOUT,
   output logic              HRESP,
   output block_t            blk_data,
   output logic              blk_valid,
   input  logic              blk_ready,
   input  block_t            res_data,
   input  logic              res_valid,
   output logic              res_ready,
   output logic [191:0]      key,
   output logic              mode
);

   localparam int AL        = (DATA_W == 64) ? 3 : 2;
   localparam bit WIDE      = (DATA_W == 64);
   localparam int KEY_WORDS = 192 / DATA_W;
   localparam int IW        = $clog2(IN_DEPTH) + 1;
   localparam int OW        = $clog2(OUT_DEPTH) + 1;

   err_state_t    state, state_next;
   logic          addr_active, addr_error, addr_ok;
   logic [3:0]    addr_idx;
   logic          dp_valid, dp_write;
   logic [3:0]    dp_idx;
   logic          wr_commit, rd_commit, flush;
   logic          dp_in_push, dp_out_pop;
   logic          in_would_full, out_would_empty;
   logic          in_full, in_empty, out_full, out_empty;
   logic [IW-1:0] in_count;
   logic [OW-1:0] out_count;
   block_t        in_push_data, out_head;
   logic          in_half, out_half, err;
   logic [31:0]   in_lo;
   logic          key_hit;
   logic [2:0]    key_word;
   logic          unused_ok;

   assign unused_ok = ^{HMASTLOCK, HBURST, HPROT, HADDR[31:AL+4], HADDR[AL-1:0]};

   assign addr_active = HSEL && HREADY && (state != ERR1) &&
                        (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
   assign addr_idx    = HADDR[AL+3:AL];

   assign wr_commit  = dp_valid && dp_write;
   assign rd_commit  = dp_valid && !dp_write;
   assign dp_in_push = wr_commit && dp_idx == IDX_DATA_IN && (WIDE || in_half);
   assign dp_out_pop = rd_commit && dp_idx == IDX_DATA_OUT && (WIDE || out_half);
   assign flush      = wr_commit && dp_idx == IDX_CTRL && HWDATA[CTRL_FLUSH];

   assign in_would_full   = (in_count == IW'(IN_DEPTH)) ||
                            (dp_in_push && in_count == IW'(IN_DEPTH - 1));
   assign out_would_empty = (out_count == '0) ||
                            (dp_out_pop && out_count == OW'(1));

   assign addr_error = addr_active &&
                       (addr_idx >= IDX_RSVD_FIRST || HSIZE != 3'(AL) ||
                        (HWRITE && addr_idx == IDX_DATA_IN && in_would_full) ||
                        (!HWRITE && addr_idx == IDX_DATA_OUT && out_would_empty));
   assign addr_ok    = addr_active && !addr_error;

   assign key_hit  = dp_idx >= IDX_KEY0 && dp_idx < IDX_KEY0 + 4'(KEY_WORDS);
   assign key_word = 3'(dp_idx - IDX_KEY0);

   assign in_push_data = WIDE ? block_t'(HWDATA) : {HWDATA[31:0], in_lo};
   assign blk_valid    = !in_empty;
   assign res_ready    = !out_full;

   des_block_fifo #(.DEPTH(IN_DEPTH)) u_in_fifo (
      .clock(HCLK), .reset(HRESET), .flush(flush),
      .push(dp_in_push), .push_data(in_push_data),
      .pop(blk_valid && blk_ready), .pop_data(blk_data),
      .full(in_full), .empty(in_empty), .count(in_count)
   );

   des_block_fifo #(.DEPTH(OUT_DEPTH)) u_out_fifo (
      .clock(HCLK), .reset(HRESET), .flush(flush),
      .push(res_valid && res_ready), .push_data(res_data),
      .pop(dp_out_pop), .pop_data(out_head),
      .full(out_full), .empty(out_empty), .count(out_count)
   );

   // Error response state register.
   always_ff @(posedge HCLK) begin
      if (HRESET) state <= IDLE;
      else        state <= state_next;
   end

   // ERROR takes a stalled first cycle then a ready second cycle.
   always_comb begin
      state_next = IDLE;
      HREADYOUT  = 1'b1;
      HRESP      = HRESP_OKAY;
      case (state)
         IDLE: begin
            if (addr_error) state_next = ERR1;
         end
         ERR1: begin
            state_next = ERR2;
            HREADYOUT  = 1'b0;
            HRESP      = HRESP_ERROR;
         end
         ERR2: begin
            HRESP = HRESP_ERROR;
            if (addr_error) state_next = ERR1;
         end
         default: state_next = IDLE;
      endcase
   end

   // Address phase capture; rejected transfers never reach a data phase.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_idx   <= '0;
      end else begin
         dp_valid <= addr_ok;
         dp_write <= HWRITE;
         dp_idx   <= addr_idx;
      end
   end

   // Register file and half-word phase flags, updated at the end of the data phase.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         key      <= '0;
         mode     <= 1'b0;
         err      <= 1'b0;
         in_half  <= 1'b0;
         out_half <= 1'b0;
         in_lo    <= '0;
      end else begin
         if (addr_error)
            err <= 1'b1;
         else if (wr_commit && dp_idx == IDX_STATUS && HWDATA[ST_ERR])
            err <= 1'b0;
         if (wr_commit && dp_idx == IDX_CTRL)
            mode <= HWDATA[CTRL_MODE];
         if (wr_commit && key_hit)
            key[key_word*DATA_W +: DATA_W] <= HWDATA;
         if (flush) begin
            in_half  <= 1'b0;
            out_half <= 1'b0;
         end else begin
            if (!WIDE && wr_commit && dp_idx == IDX_DATA_IN) begin
               if (!in_half) in_lo <= HWDATA[31:0];
               in_half <= !in_half;
            end
            if (!WIDE && rd_commit && dp_idx == IDX_DATA_OUT)
               out_half <= !out_half;
         end
      end
   end

   // Read data mux, driven only during an accepted read data phase.
   always_comb begin
      HRDATA = '0;
      if (rd_commit) begin
         case (dp_idx)
            IDX_CTRL:     HRDATA[CTRL_MODE] = mode;
            IDX_STATUS: begin
               HRDATA[ST_IN_FULL]   = in_full;
               HRDATA[ST_IN_EMPTY]  = in_empty;
               HRDATA[ST_OUT_FULL]  = out_full;
               HRDATA[ST_OUT_EMPTY] = out_empty;
               HRDATA[ST_ERR]       = err;
            end
            IDX_DATA_OUT: HRDATA = DATA_W'(out_head >> (out_half ? 32 : 0));
            default: begin
               if (key_hit) HRDATA = key[key_word*DATA_W +: DATA_W];
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_des_port.sv
// Directed bench for ahb_des_port: one 64-bit and one 32-bit instance
// sharing the AHB address/data wires, with separate select and core sides.
module tb_ahb_des_port;
   import des_ahb_pkg::*;

   localparam logic [3:0] OKAY_R = 4'b0100;
   localparam logic [3:0] ERR_R  = 4'b1011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [63:0] hwdata;
   logic        hsel64, hsel32;

   logic [63:0]  hrdata64;
   logic         hreadyout64, hresp64;
   block_t       blk_data64, res_data64;
   logic         blk_valid64, blk_ready64, res_valid64, res_ready64, mode64;
   logic [191:0] key64;

   logic [31:0]  hrdata32;
   logic         hreadyout32, hresp32;
   block_t       blk_data32, res_data32;
   logic         blk_valid32, blk_ready32, res_valid32, res_ready32, mode32;
   logic [191:0] key32;

   int checks   = 0;
   int failures = 0;

   ahb_des_port #(.DATA_W(64), .IN_DEPTH(4), .OUT_DEPTH(4)) u64 (
      .HCLK(clk), .HRESET(reset), .HSEL(hsel64), .HWRITE(hwrite),
      .HMASTLOCK(1'b0), .HREADY(hreadyout64), .HTRANS(htrans), .HSIZE(hsize),
      .HBURST(3'b000), .HPROT(4'b0011), .HADDR(haddr), .HWDATA(hwdata),
      .HRDATA(hrdata64), .HREADYOUT(hreadyout64), .HRESP(hresp64),
      .blk_data(blk_data64), .blk_valid(blk_valid64), .blk_ready(blk_ready64),
      .res_data(res_data64), .res_valid(res_valid64), .res_ready(res_ready64),
      .key(key64), .mode(mode64)
   );

   ahb_des_port #(.DATA_W(32), .IN_DEPTH(4), .OUT_DEPTH(4)) u32 (
      .HCLK(clk), .HRESET(reset), .HSEL(hsel32), .HWRITE(hwrite),
      .HMASTLOCK(1'b0), .HREADY(hreadyout32), .HTRANS(htrans), .HSIZE(hsize),
      .HBURST(3'b000), .HPROT(4'b0011), .HADDR(haddr), .HWDATA(hwdata[31:0]),
      .HRDATA(hrdata32), .HREADYOUT(hreadyout32), .HRESP(hresp32),
      .blk_data(blk_data32), .blk_valid(blk_valid32), .blk_ready(blk_ready32),
      .res_data(res_data32), .res_valid(res_valid32), .res_ready(res_ready32),
      .key(key32), .mode(mode32)
   );

   task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One single transfer; resp = {HRESP, HREADYOUT} of data cycle 1 and, on ERROR, cycle 2.
   task automatic applyStimulus(input bit is32, input bit wr, input logic [3:0] idx,
                                input logic [63:0] wdata, input logic [2:0] size,
                                output logic [63:0] rdata, output logic [3:0] resp);
      @(negedge clk);
      hsel64 = !is32;
      hsel32 = is32;
      htrans = HTRANS_NONSEQ;
      hwrite = wr;
      hsize  = size;
      haddr  = is32 ? {26'b0, idx, 2'b00} : {25'b0, idx, 3'b000};
      @(negedge clk);
      hsel64 = 1'b0;
      hsel32 = 1'b0;
      htrans = HTRANS_IDLE;
      hwdata = wdata;
      rdata  = is32 ? {32'b0, hrdata32} : hrdata64;
      resp   = {is32 ? {hresp32, hreadyout32} : {hresp64, hreadyout64}, 2'b00};
      if (resp[3:2] == 2'b10) begin
         @(negedge clk);
         resp[1:0] = is32 ? {hresp32, hreadyout32} : {hresp64, hreadyout64};
      end
   endtask

   task automatic doWrite(input bit is32, input logic [3:0] idx, input logic [63:0] d,
                          input logic [3:0] expResp, input string tag);
      logic [63:0] rd;
      logic [3:0]  rs;
      applyStimulus(is32, 1'b1, idx, d, is32 ? 3'd2 : 3'd3, rd, rs);
      checkOutput({tag, "_resp"}, rs, expResp);
   endtask

   task automatic doRead(input bit is32, input logic [3:0] idx, input logic [63:0] expData,
                         input logic [3:0] expResp, input string tag);
      logic [63:0] rd;
      logic [3:0]  rs;
      applyStimulus(is32, 1'b0, idx, 64'h0, is32 ? 3'd2 : 3'd3, rd, rs);
      checkOutput({tag, "_resp"}, rs, expResp);
      checkOutput({tag, "_data"}, rd, expData);
   endtask

   // Directed sequence covering reset, registers, FIFOs, errors, flush and 32-bit halves.
   initial begin
      logic [63:0] rd;
      logic [3:0]  rs;
      block_t      drain [4];

      reset = 1'b1;
      haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
      hsel64 = 1'b0; hsel32 = 1'b0;
      blk_ready64 = 1'b0; res_valid64 = 1'b0; res_data64 = '0;
      blk_ready32 = 1'b0; res_valid32 = 1'b0; res_data32 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_hreadyout", hreadyout64, 1'b1);
      checkOutput("rst_hresp", hresp64, 1'b0);
      checkOutput("rst_hrdata", hrdata64, 64'h0);
      checkOutput("rst_blk_valid", blk_valid64, 1'b0);
      checkOutput("rst_res_ready", res_ready64, 1'b1);
      checkOutput("rst_key", key64, 192'h0);
      checkOutput("rst_mode", mode64, 1'b0);
      reset = 1'b0;

      doRead(0, IDX_STATUS, 64'h0A, OKAY_R, "status_reset");

      doWrite(0, 4'd2, 64'h0123456789ABCDEF, OKAY_R, "key1");
      doWrite(0, 4'd3, 64'h23456789ABCDEF01, OKAY_R, "key2");
      doWrite(0, 4'd4, 64'h456789ABCDEF0123, OKAY_R, "key3");
      @(negedge clk);
      checkOutput("key_out", key64,
                  {64'h456789ABCDEF0123, 64'h23456789ABCDEF01, 64'h0123456789ABCDEF});
      doRead(0, 4'd3, 64'h23456789ABCDEF01, OKAY_R, "key2_rd");
      doRead(0, 4'd5, 64'h0, OKAY_R, "unused_idx_rd");

      doWrite(0, IDX_DATA_IN, 64'h4E6F772069732074, OKAY_R, "din0");
      checkOutput("blk_valid_before_commit", blk_valid64, 1'b0);
      @(negedge clk);
      checkOutput("blk_valid_after_commit", blk_valid64, 1'b1);
      checkOutput("blk_data_first", blk_data64, 64'h4E6F772069732074);

      doWrite(0, IDX_CTRL, 64'h1, OKAY_R, "ctrl_mode");
      @(negedge clk);
      checkOutput("mode_set", mode64, 1'b1);
      doRead(0, IDX_CTRL, 64'h1, OKAY_R, "ctrl_rd");

      doWrite(0, IDX_DATA_IN, 64'h1111111111111111, OKAY_R, "din1");
      doWrite(0, IDX_DATA_IN, 64'h2222222222222222, OKAY_R, "din2");
      doWrite(0, IDX_DATA_IN, 64'h3333333333333333, OKAY_R, "din3");
      doWrite(0, IDX_DATA_IN, 64'h4444444444444444, ERR_R, "din_full");
      doRead(0, IDX_STATUS, 64'h19, OKAY_R, "status_full_err");
      drain = '{64'h4E6F772069732074, 64'h1111111111111111,
                64'h2222222222222222, 64'h3333333333333333};
      blk_ready64 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("drain%0d_valid", i), blk_valid64, 1'b1);
         checkOutput($sformatf("drain%0d_data", i), blk_data64, drain[i]);
         @(negedge clk);
      end
      checkOutput("drain_empty", blk_valid64, 1'b0);
      blk_ready64 = 1'b0;

      doWrite(0, IDX_STATUS, 64'h10, OKAY_R, "err_clear");
      doRead(0, IDX_STATUS, 64'h0A, OKAY_R, "status_cleared");

      doRead(0, IDX_DATA_OUT, 64'h0, ERR_R, "dout_empty");
      doRead(0, IDX_STATUS, 64'h1A, OKAY_R, "status_dout_err");
      @(negedge clk);
      checkOutput("res_ready_idle", res_ready64, 1'b1);
      res_valid64 = 1'b1;
      res_data64  = 64'h3FA40E8A984D4815;
      @(negedge clk);
      res_valid64 = 1'b0;
      doRead(0, IDX_STATUS, 64'h12, OKAY_R, "status_result");
      doRead(0, IDX_DATA_OUT, 64'h3FA40E8A984D4815, OKAY_R, "dout_result");
      doRead(0, IDX_STATUS, 64'h1A, OKAY_R, "status_popped");

      applyStimulus(0, 1'b0, IDX_STATUS, 64'h0, 3'd2, rd, rs);
      checkOutput("bad_hsize_resp", rs, ERR_R);
      doRead(0, 4'd12, 64'h0, ERR_R, "reserved_idx");
      doWrite(0, IDX_STATUS, 64'h10, OKAY_R, "err_clear2");
      doRead(0, IDX_STATUS, 64'h0A, OKAY_R, "status_cleared2");

      doWrite(0, IDX_DATA_IN, 64'hAAAAAAAAAAAAAAAA, OKAY_R, "fl_din0");
      doWrite(0, IDX_DATA_IN, 64'hBBBBBBBBBBBBBBBB, OKAY_R, "fl_din1");
      doWrite(0, IDX_DATA_IN, 64'hCCCCCCCCCCCCCCCC, OKAY_R, "fl_din2");
      doWrite(0, IDX_CTRL, 64'h2, OKAY_R, "flush");
      res_valid64 = 1'b1;
      res_data64  = 64'hDEADBEEFDEADBEEF;
      @(negedge clk);
      res_valid64 = 1'b0;
      checkOutput("flush_blk_valid", blk_valid64, 1'b0);
      doRead(0, IDX_STATUS, 64'h0A, OKAY_R, "status_flushed");
      doRead(0, IDX_CTRL, 64'h0, OKAY_R, "ctrl_after_flush");

      doWrite(1, IDX_DATA_IN, 64'h69732074, OKAY_R, "w32_lo");
      @(negedge clk);
      checkOutput("w32_no_block_yet", blk_valid32, 1'b0);
      doWrite(1, IDX_DATA_IN, 64'h4E6F7720, OKAY_R, "w32_hi");
      @(negedge clk);
      checkOutput("w32_blk_valid", blk_valid32, 1'b1);
      checkOutput("w32_blk_data", blk_data32, 64'h4E6F772069732074);
      doWrite(1, 4'd7, 64'hDEADBEEF, OKAY_R, "w32_key_top");
      @(negedge clk);
      checkOutput("w32_key", key32, {32'hDEADBEEF, 160'h0});
      res_valid32 = 1'b1;
      res_data32  = 64'h3FA40E8A984D4815;
      @(negedge clk);
      res_valid32 = 1'b0;
      doRead(1, IDX_DATA_OUT, 64'h984D4815, OKAY_R, "r32_lo");
      doRead(1, IDX_DATA_OUT, 64'h3FA40E8A, OKAY_R, "r32_hi");
      doRead(1, IDX_STATUS, 64'h08, OKAY_R, "r32_status");
      doRead(1, IDX_DATA_OUT, 64'h0, ERR_R, "r32_empty");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb_des_port.md
# ahb_des_port

AHB-Lite slave port for the Triple DES engine, replacing the fixed 64-bit bus wrapper: parametrised bus width (32 or 64), buffered input/output block FIFOs and a memory-mapped control/key/status register file.
- Sits between the system AHB fabric and the DES datapath.
- Owns all bus protocol handling, including wait-free OKAY and two-cycle ERROR responses.
- Presents the core with valid/ready block streams plus key and mode.

## Interface
- DATA_W, 64, AHB data width; 32 or 64 only.
- IN_DEPTH, 4, input block FIFO depth; power of two, ≥2.
- OUT_DEPTH, 4, output block FIFO depth; power of two, ≥2.
- Clocking: one clock `HCLK`; reset `HRESET` is synchronous and active-high.
- HCLK  in  1  clock
- HRESET  in  1  synchronous active-high reset
- HSEL, HWRITE, HMASTLOCK, HREADY  in  1  AHB-Lite control (HMASTLOCK ignored)
- HTRANS  in  2  transfer type; active when HSEL & HREADY & HTRANS[1]
- HSIZE, HBURST  in  3  size (must equal log2(DATA_W/8)); burst ignored
- HPROT  in  4  ignored
- HADDR  in  32  address; register index = HADDR[AL+3:AL], AL = log2(DATA_W/8)
- HWDATA  in  DATA_W  write data, data phase
- HRDATA  out  DATA_W  read data, data phase
- HREADYOUT  out  1  transfer done
- HRESP  out  1  0 OKAY, 1 ERROR
- blk_data/blk_valid/blk_ready  out/out/in  64/1/1  block stream to core
- res_data/res_valid/res_ready  in/in/out  64/1/1  result stream from core
- key  out  192  {K3,K2,K1}
- mode  out  1  0 encrypt, 1 decrypt

## Operation
- Register indexes:
  - 0 CTRL: bit0 mode; bit1 flush, write-1, self-clearing, reads 0.
  - 1 STATUS (RO): in_full, in_empty, out_full, out_empty, err; writing 1 to bit4 clears err.
  - 2.. KEY words, LSW first, 192/DATA_W words; unused indexes up to 7 read 0, writes ignored, OKAY.
  - 8 DATA_IN (WO).
  - 9 DATA_OUT (RO).
  - 10–15 reserved.
- ERROR conditions, decided at address phase:
  - index ≥10;
  - wrong HSIZE;
  - write to DATA_IN when the input FIFO is full, counting an in-flight push;
  - read of DATA_OUT when the output FIFO is empty;
  - write to DATA_OUT or STATUS bits 3:0 is ignored and gives OKAY.
- On ERROR: no side effect, and err is set.
- DATA_W=32, DATA_IN: the first write latches the low half. The second write pushes {hi,lo}. A half flag tracks the phase.
- DATA_W=32, DATA_OUT: the first read returns the low half. The second read returns the high half and pops. A separate half flag tracks the phase.
- Core side:
  - blk_valid = !in_empty; pop on blk_valid & blk_ready.
  - res_ready = !out_full; push on res_valid & res_ready.
- Flush clears both FIFOs and both half flags. A core push in the same cycle is dropped.

## Timing
- Reset values:
  - HRDATA 0, HREADYOUT 1, HRESP 0, blk_valid 0, res_ready 1, key 0, mode 0;
  - FIFOs empty, half flags 0, err 0.
- Reset mid-transfer discards the pending data phase.
- OKAY transfers take zero wait states. Writes commit at the edge ending the data phase.
- HRDATA is valid during the read data phase and is 0 otherwise. The DATA_OUT pop occurs at the edge ending that data phase.
- ERROR response:
  - cycle 1: HRESP=1, HREADYOUT=0;
  - cycle 2: HRESP=1, HREADYOUT=1;
  - any address phase presented during cycle 1 is ignored.
- FIFO push and pop in the same cycle:
  - on a full FIFO: both occur and the count is unchanged;
  - on an empty FIFO: the pop is not allowed (valid is low).
- blk_valid rises 1 cycle after the DATA_IN commit. STATUS reflects the change on the next read.
- FIFO pointers wrap modulo depth. Occupancy counters are log2(depth)+1 bits wide.

## Structure
- Package des_ahb_pkg:
  - register index constants;
  - CTRL/STATUS bit positions;
  - HTRANS/HRESP encodings;
  - block_t = logic [63:0].
- Sub-module des_block_fifo #(DEPTH):
  - sync FIFO of block_t with push, pop, full, empty, flush;
  - instantiated twice.
- Top handles the address/data phase pipeline, error FSM (IDLE, ERR1, ERR2), register file and half-word assembly.

## Test plan
- Reset, then read STATUS. Required: 0x0A (both FIFOs empty), OKAY, HREADYOUT high.
- DATA_W=64: write keys 0x0123456789ABCDEF/0x23456789ABCDEF01/0x456789ABCDEF0123 and write DATA_IN 0x4E6F772069732074. Required:
  - key = {K3,K2,K1};
  - blk_data = 0x4E6F772069732074 with blk_valid one cycle later.
- Fill the input FIFO with 4 writes, blk_ready=0, then a 5th write. Required: two-cycle ERROR, STATUS.err=1, FIFO contents unchanged.
- Read DATA_OUT while empty. Required: ERROR, no pop. Then core pushes 0x3FA40E8A984D4815 and a read returns it with OKAY.
- DATA_W=32: write lo 0x69732074, then hi 0x4E6F7720. Required: a single block 0x4E6F772069732074. Reading two halves of a result returns lo then hi.
- Flush with 3 blocks queued and res_valid asserted the same cycle. Required: both FIFOs empty, blk_valid 0 next cycle, the pushed result dropped.
